// File: rtl/latch_word_loader.sv
// latch_word_loader: packs handshaked bytes into 16-bit words and strobes each into a transparent latch via a timed active-low enable.
module latch_word_loader #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [15:0] data_out,
    output logic        l_en,
    output logic        busy,
    output logic [7:0]  word_count
);
    localparam logic [2:0] S_IDLE = 3'd0, S_GOT_LO = 3'd1, S_SETUP = 3'd2, S_STROBE = 3'd3, S_HOLD = 3'd4;
    localparam int MAXC = (SETUP_CYC > STROBE_CYC) ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                                                   : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
    localparam int CW = (MAXC < 2) ? 1 : $clog2(MAXC);
    localparam logic [CW-1:0] SETUP_LD  = CW'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
    localparam logic [CW-1:0] STROBE_LD = CW'((STROBE_CYC > 0) ? STROBE_CYC - 1 : 0);
    localparam logic [CW-1:0] HOLD_LD   = CW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
    localparam logic [2:0]    FORM_ST   = (SETUP_CYC > 0) ? S_SETUP : S_STROBE;
    localparam logic [CW-1:0] FORM_LD   = (SETUP_CYC > 0) ? SETUP_LD : STROBE_LD;
    localparam logic [2:0]    POST_ST   = (HOLD_CYC > 0) ? S_HOLD : S_IDLE;

    if (STROBE_CYC < 1) begin : g_bad_strobe
        $error("latch_word_loader: STROBE_CYC must be at least 1");
    end

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    part_q, part_d;
    logic [15:0]   data_q, data_d;
    logic [7:0]    count_q, count_d;
    logic          l_en_q, busy_q;
    logic          accept, cnt_done;
    logic [15:0]   word_single, word_pair;

    assign in_ready    = rst_n & (state_q == S_IDLE | state_q == S_GOT_LO);
    assign accept      = in_valid & in_ready;
    assign cnt_done    = cnt_q == '0;
    assign word_single = LSB_FIRST ? {8'h00, in_data} : {in_data, 8'h00};
    assign word_pair   = LSB_FIRST ? {in_data, part_q} : {part_q, in_data};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        part_d  = part_q;
        data_d  = data_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: if (accept) begin
                if (in_last) begin
                    data_d  = word_single;
                    state_d = FORM_ST;
                    cnt_d   = FORM_LD;
                end else begin
                    part_d  = in_data;
                    state_d = S_GOT_LO;
                end
            end
            S_GOT_LO: if (accept) begin
                data_d  = word_pair;
                state_d = FORM_ST;
                cnt_d   = FORM_LD;
            end
            S_SETUP: begin
                state_d = cnt_done ? S_STROBE : S_SETUP;
                cnt_d   = cnt_done ? STROBE_LD : cnt_q - CW'(1);
            end
            S_STROBE: begin
                state_d = cnt_done ? POST_ST : S_STROBE;
                cnt_d   = cnt_done ? HOLD_LD : cnt_q - CW'(1);
                count_d = cnt_done ? count_q + 8'd1 : count_q;
            end
            S_HOLD: begin
                state_d = cnt_done ? S_IDLE : S_HOLD;
                cnt_d   = cnt_done ? '0 : cnt_q - CW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // l_en and busy are registered from next state so they stay glitch-free
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            part_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
            l_en_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            part_q  <= part_d;
            data_q  <= data_d;
            count_q <= count_d;
            l_en_q  <= state_d != S_STROBE;
            busy_q  <= (state_d == S_SETUP) | (state_d == S_STROBE) | (state_d == S_HOLD);
        end
    end

    assign data_out   = data_q;
    assign l_en       = l_en_q;
    assign busy       = busy_q;
    assign word_count = count_q;
endmodule

// File: tb/tb_latch_word_loader.sv
// tb_latch_word_loader: three parameterisations checked by directed scenarios and a timing-window reference model.
module tb_latch_word_loader;
    localparam int PS [3] = '{1, 1, 0};
    localparam int PT [3] = '{2, 2, 1};
    localparam int PH [3] = '{1, 1, 0};
    localparam bit PL [3] = '{1'b1, 1'b0, 1'b1};
    localparam int IDLE_AGE = 1000;

    logic clk = 1'b0;
    logic [2:0] rst_n, in_valid, in_last, in_ready, l_en, busy;
    logic [2:0][7:0] in_data, word_count;
    logic [2:0][15:0] data_out;
    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    genvar g;
    for (g = 0; g < 3; g++) begin : g_dut
        latch_word_loader #(.SETUP_CYC(PS[g]), .STROBE_CYC(PT[g]), .HOLD_CYC(PH[g]), .LSB_FIRST(PL[g])) dut (
            .clk(clk), .rst_n(rst_n[g]), .in_data(in_data[g]), .in_valid(in_valid[g]), .in_last(in_last[g]),
            .in_ready(in_ready[g]), .data_out(data_out[g]), .l_en(l_en[g]), .busy(busy[g]), .word_count(word_count[g])
        );
    end

    int         m_age  [3];
    logic [15:0] m_word [3];
    logic [7:0]  m_cnt  [3];
    logic [7:0]  m_part [3];
    bit          m_lo   [3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n[i]) begin
                m_age[i] = IDLE_AGE; m_word[i] = 16'h0; m_cnt[i] = 8'h0; m_part[i] = 8'h0; m_lo[i] = 1'b0;
            end else begin
                bit acc;
                acc = in_valid[i] && (m_age[i] >= PS[i] + PT[i] + PH[i]);
                if (m_age[i] < IDLE_AGE) m_age[i]++;
                if (m_age[i] == PS[i] + PT[i]) m_cnt[i]++;
                if (acc) begin
                    if (m_lo[i]) begin
                        m_word[i] = PL[i] ? {in_data[i], m_part[i]} : {m_part[i], in_data[i]};
                        m_age[i] = 0; m_lo[i] = 1'b0;
                    end else if (in_last[i]) begin
                        m_word[i] = PL[i] ? {8'h00, in_data[i]} : {in_data[i], 8'h00};
                        m_age[i] = 0;
                    end else begin
                        m_part[i] = in_data[i]; m_lo[i] = 1'b1;
                    end
                end
            end
        end
    end

    function automatic bit exp_ready(int i);
        return rst_n[i] && m_age[i] >= PS[i] + PT[i] + PH[i];
    endfunction
    function automatic bit exp_len(int i);
        return !(m_age[i] >= PS[i] && m_age[i] < PS[i] + PT[i]);
    endfunction
    function automatic bit exp_busy(int i);
        return m_age[i] < PS[i] + PT[i] + PH[i];
    endfunction

    task automatic send_byte(int i, logic [7:0] d, logic last);
        in_valid[i] = 1'b1; in_data[i] = d; in_last[i] = last;
        @(negedge clk);
        in_valid[i] = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = '0; in_valid = '0; in_last = '0; in_data = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++; if (data_out[i] !== 16'h0) begin fails++; $display("FAIL reset_data[%0d] got=%h exp=0000", i, data_out[i]); end
            checks++; if (l_en[i] !== 1'b1) begin fails++; $display("FAIL reset_len[%0d] got=%b exp=1", i, l_en[i]); end
            checks++; if (word_count[i] !== 8'h0) begin fails++; $display("FAIL reset_count[%0d] got=%0d exp=0", i, word_count[i]); end
            checks++; if (busy[i] !== 1'b0) begin fails++; $display("FAIL reset_busy[%0d] got=%b exp=0", i, busy[i]); end
            checks++; if (in_ready[i] !== 1'b0) begin fails++; $display("FAIL reset_ready[%0d] got=%b exp=0", i, in_ready[i]); end
        end
        rst_n = '1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++; if (in_ready[i] !== 1'b1) begin fails++; $display("FAIL release_ready[%0d] got=%b exp=1", i, in_ready[i]); end
        end
    endtask

    task automatic test_basic;
        send_byte(0, 8'h34, 1'b0);
        send_byte(0, 8'h12, 1'b0);
        checks++; if (data_out[0] !== 16'h1234) begin fails++; $display("FAIL basic_data got=%h exp=1234", data_out[0]); end
        for (int k = 0; k < 6; k++) begin
            checks++; if (l_en[0] !== !(k == 1 || k == 2)) begin fails++; $display("FAIL basic_len k=%0d got=%b exp=%b", k, l_en[0], !(k == 1 || k == 2)); end
            checks++; if (in_ready[0] !== (k >= 4)) begin fails++; $display("FAIL basic_ready k=%0d got=%b exp=%b", k, in_ready[0], k >= 4); end
            checks++; if (l_en[0] !== exp_len(0)) begin fails++; $display("FAIL basic_model_len k=%0d got=%b exp=%b", k, l_en[0], exp_len(0)); end
            if (k == 2) begin checks++; if (word_count[0] !== 8'd0) begin fails++; $display("FAIL basic_count_early got=%0d exp=0", word_count[0]); end end
            @(negedge clk);
        end
        checks++; if (word_count[0] !== 8'd1) begin fails++; $display("FAIL basic_count got=%0d exp=1", word_count[0]); end
    endtask

    task automatic test_msb;
        int lows = 0;
        send_byte(1, 8'hAB, 1'b0);
        send_byte(1, 8'hCD, 1'b0);
        checks++; if (data_out[1] !== 16'hABCD) begin fails++; $display("FAIL msb_data got=%h exp=abcd", data_out[1]); end
        repeat (4) @(negedge clk);
        send_byte(1, 8'h7F, 1'b1);
        checks++; if (data_out[1] !== 16'h7F00) begin fails++; $display("FAIL msb_single_data got=%h exp=7f00", data_out[1]); end
        for (int k = 0; k < 6; k++) begin
            if (l_en[1] === 1'b0) lows++;
            @(negedge clk);
        end
        checks++; if (lows != 2) begin fails++; $display("FAIL msb_single_strobe low_cycles=%0d exp=2", lows); end
        checks++; if (word_count[1] !== 8'd2) begin fails++; $display("FAIL msb_count got=%0d exp=2", word_count[1]); end
    endtask

    task automatic test_fast;
        send_byte(2, 8'hAB, 1'b0);
        send_byte(2, 8'h12, 1'b0);
        checks++; if (l_en[2] !== 1'b0) begin fails++; $display("FAIL fast_len0 got=%b exp=0", l_en[2]); end
        checks++; if (in_ready[2] !== 1'b0) begin fails++; $display("FAIL fast_ready0 got=%b exp=0", in_ready[2]); end
        checks++; if (data_out[2] !== 16'h12AB) begin fails++; $display("FAIL fast_data got=%h exp=12ab", data_out[2]); end
        @(negedge clk);
        checks++; if (l_en[2] !== 1'b1) begin fails++; $display("FAIL fast_len1 got=%b exp=1", l_en[2]); end
        checks++; if (in_ready[2] !== 1'b1) begin fails++; $display("FAIL fast_ready1 got=%b exp=1", in_ready[2]); end
        checks++; if (word_count[2] !== 8'd1) begin fails++; $display("FAIL fast_count1 got=%0d exp=1", word_count[2]); end
        send_byte(2, 8'h5A, 1'b1);
        checks++; if (l_en[2] !== 1'b0) begin fails++; $display("FAIL fast_len2 got=%b exp=0", l_en[2]); end
        checks++; if (data_out[2] !== 16'h005A) begin fails++; $display("FAIL fast_data2 got=%h exp=005a", data_out[2]); end
        @(negedge clk);
        checks++; if (word_count[2] !== 8'd2) begin fails++; $display("FAIL fast_count2 got=%0d exp=2", word_count[2]); end
    endtask

    task automatic test_stream;
        logic [7:0] bytes [512];
        logic [7:0] c0;
        int idx = 0, nstrobe = 0, cyc = 0;
        bit prev_len, will;
        for (int j = 0; j < 512; j++) bytes[j] = 8'($urandom);
        c0 = m_cnt[0];
        prev_len = l_en[0];
        in_valid[0] = 1'b1; in_last[0] = 1'b0;
        while (cyc < 4100) begin
            if (idx < 512) in_data[0] = bytes[idx]; else in_valid[0] = 1'b0;
            will = in_valid[0] && exp_ready(0);
            checks++; if (in_ready[0] !== exp_ready(0)) begin fails++; $display("FAIL stream_ready cyc=%0d got=%b exp=%b", cyc, in_ready[0], exp_ready(0)); end
            checks++; if (l_en[0] !== exp_len(0)) begin fails++; $display("FAIL stream_len cyc=%0d got=%b exp=%b", cyc, l_en[0], exp_len(0)); end
            checks++; if (busy[0] !== exp_busy(0)) begin fails++; $display("FAIL stream_busy cyc=%0d got=%b exp=%b", cyc, busy[0], exp_busy(0)); end
            checks++; if (word_count[0] !== m_cnt[0]) begin fails++; $display("FAIL stream_count cyc=%0d got=%0d exp=%0d", cyc, word_count[0], m_cnt[0]); end
            checks++; if (in_ready[0] && busy[0]) begin fails++; $display("FAIL stream_ready_busy cyc=%0d got=1 exp=0", cyc); end
            if (prev_len && !l_en[0]) begin
                checks++;
                if (nstrobe >= 256) begin fails++; $display("FAIL stream_extra_strobe got=%0d exp=256", nstrobe + 1); end
                else if (data_out[0] !== {bytes[2*nstrobe+1], bytes[2*nstrobe]}) begin
                    fails++; $display("FAIL stream_word[%0d] got=%h exp=%h", nstrobe, data_out[0], {bytes[2*nstrobe+1], bytes[2*nstrobe]});
                end
                nstrobe++;
            end
            prev_len = l_en[0];
            @(negedge clk);
            if (will) idx++;
            cyc++;
            if (idx == 512 && !exp_busy(0) && nstrobe >= 256) break;
        end
        in_valid[0] = 1'b0;
        checks++; if (idx != 512) begin fails++; $display("FAIL stream_timeout bytes=%0d exp=512", idx); end
        checks++; if (nstrobe != 256) begin fails++; $display("FAIL stream_strobes got=%0d exp=256", nstrobe); end
        checks++; if (word_count[0] !== c0) begin fails++; $display("FAIL stream_wrap got=%0d exp=%0d", word_count[0], c0); end
    endtask

    task automatic test_reset_mid;
        send_byte(0, 8'h11, 1'b0);
        send_byte(0, 8'h22, 1'b0);
        @(negedge clk);
        checks++; if (l_en[0] !== 1'b0) begin fails++; $display("FAIL rmid_strobe got=%b exp=0", l_en[0]); end
        rst_n[0] = 1'b0;
        #1;
        checks++; if (in_ready[0] !== 1'b0) begin fails++; $display("FAIL rmid_ready_low got=%b exp=0", in_ready[0]); end
        @(negedge clk);
        checks++; if (l_en[0] !== 1'b1) begin fails++; $display("FAIL rmid_len got=%b exp=1", l_en[0]); end
        checks++; if (data_out[0] !== 16'h0) begin fails++; $display("FAIL rmid_data got=%h exp=0000", data_out[0]); end
        checks++; if (word_count[0] !== 8'h0) begin fails++; $display("FAIL rmid_count got=%0d exp=0", word_count[0]); end
        rst_n[0] = 1'b1;
        @(negedge clk);
        checks++; if (in_ready[0] !== 1'b1) begin fails++; $display("FAIL rmid_ready_after got=%b exp=1", in_ready[0]); end
        checks++; if (word_count[0] !== 8'h0) begin fails++; $display("FAIL rmid_count_after got=%0d exp=0", word_count[0]); end
    endtask

    task automatic test_gap;
        int lows = 0;
        send_byte(0, 8'h55, 1'b0);
        for (int k = 0; k < 20; k++) begin
            checks++; if (l_en[0] !== 1'b1 || busy[0] !== 1'b0 || in_ready[0] !== 1'b1 || data_out[0] !== 16'h0) begin
                fails++; $display("FAIL gap_wait k=%0d got len=%b busy=%b rdy=%b data=%h exp len=1 busy=0 rdy=1 data=0000", k, l_en[0], busy[0], in_ready[0], data_out[0]);
            end
            @(negedge clk);
        end
        send_byte(0, 8'hAA, 1'b0);
        checks++; if (data_out[0] !== 16'hAA55) begin fails++; $display("FAIL gap_data got=%h exp=aa55", data_out[0]); end
        for (int k = 0; k < 6; k++) begin
            if (l_en[0] === 1'b0) lows++;
            @(negedge clk);
        end
        checks++; if (lows != 2) begin fails++; $display("FAIL gap_strobe low_cycles=%0d exp=2", lows); end
        checks++; if (word_count[0] !== 8'd1) begin fails++; $display("FAIL gap_count got=%0d exp=1", word_count[0]); end
    endtask

    task automatic test_random;
        for (int c = 0; c < 400; c++) begin
            for (int i = 1; i < 3; i++) begin
                checks++; if (in_ready[i] !== exp_ready(i) || l_en[i] !== exp_len(i) || busy[i] !== exp_busy(i)) begin
                    fails++; $display("FAIL rand_ctrl[%0d] c=%0d got rdy=%b len=%b busy=%b exp rdy=%b len=%b busy=%b", i, c, in_ready[i], l_en[i], busy[i], exp_ready(i), exp_len(i), exp_busy(i));
                end
                checks++; if (data_out[i] !== m_word[i] || word_count[i] !== m_cnt[i]) begin
                    fails++; $display("FAIL rand_data[%0d] c=%0d got data=%h cnt=%0d exp data=%h cnt=%0d", i, c, data_out[i], word_count[i], m_word[i], m_cnt[i]);
                end
                in_valid[i] = 1'($urandom_range(0, 1));
                in_last[i]  = ($urandom_range(0, 3) == 0);
                in_data[i]  = 8'($urandom);
            end
            @(negedge clk);
        end
        in_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=expired exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_basic;
        test_msb;
        test_fast;
        test_stream;
        test_reset_mid;
        test_gap;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/latch_word_loader.md
Name: latch_word_loader

Overview:
- Upstream feeder for the 16-bit transparent latch stage (active-low latch enable, 16-bit data).
- Accepts bytes over a valid/ready handshake and assembles them into 16-bit words.
- Drives each word onto a stable 16-bit bus, then generates a glitch-free active-low latch-enable pulse with programmable setup, strobe and hold windows.
- Keeps a running count of words delivered.

Parameters:
- SETUP_CYC, 1: cycles data_out is stable with l_en high before the strobe. 0 is legal and skips the SETUP state.
- STROBE_CYC, 2: cycles l_en is held low. Minimum 1; 0 is illegal and must fail an elaboration assertion.
- HOLD_CYC, 1: cycles data_out is held stable with l_en high after the strobe. 0 is legal and skips the HOLD state.
- LSB_FIRST, 1: 1 means the first accepted byte is data_out[7:0]; 0 means the first byte is data_out[15:8].

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  reset: synchronous, active-low.
- in_data  input  8  byte payload.
- in_valid  input  1  in_data is valid this cycle.
- in_last  input  1  qualifies the accepted byte as the final byte of a message; sampled only on acceptance.
- in_ready  output  1  block can accept a byte this cycle.
- data_out  output  16  assembled word to the latch data input.
- l_en  output  1  active-low latch enable to the latch stage; registered.
- busy  output  1  high in SETUP, STROBE and HOLD.
- word_count  output  8  number of words strobed, modulo 256.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, data_out=16'h0000, l_en=1, word_count=0.
  - The partial-byte register is cleared.
  - in_ready is forced to 0 while rst_n=0.
  - Reset taken mid-strobe returns l_en to 1 at that edge; the in-flight word is not counted.
- Handshake:
  - A byte is accepted at a rising edge when in_valid & in_ready.
  - in_ready = rst_n & (state==IDLE | state==GOT_LO), combinational from state.
  - in_data/in_last are don't-care when not accepted.
  - Holding in_valid low in any state has no effect.
- States: IDLE, GOT_LO, SETUP, STROBE, HOLD.
- IDLE:
  - Accept with in_last=0: store the byte as partial, go to GOT_LO.
  - Accept with in_last=1: form the word immediately with the other byte = 8'h00, load data_out, go to SETUP. If SETUP_CYC=0, go directly to STROBE.
- GOT_LO:
  - Accept (in_last ignored): form the word from the partial byte and the new byte per LSB_FIRST, load data_out, go to SETUP (or STROBE if SETUP_CYC=0).
  - No accept: wait indefinitely; the partial byte is retained.
- SETUP: l_en=1; stay SETUP_CYC cycles, then go to STROBE.
- STROBE:
  - l_en=0 for exactly STROBE_CYC cycles.
  - On the final STROBE cycle edge: word_count increments (255 wraps to 0) and the state goes to HOLD (or IDLE if HOLD_CYC=0).
- HOLD: l_en=1; stay HOLD_CYC cycles, then go to IDLE.
- l_en timing:
  - l_en is a flop output, low iff the registered state is STROBE.
  - No combinational path from inputs to l_en.
- data_out stability:
  - Changes only on the edge that forms a new word.
  - Stable throughout SETUP, STROBE and HOLD, and in IDLE/GOT_LO until the next word is formed.
- Cycle counter:
  - A single down-counter, wide enough for max(SETUP_CYC, STROBE_CYC, HOLD_CYC).
  - Reloaded on every state entry.
- Default latency:
  - Second byte accepted at edge N → data_out valid after N.
  - l_en falls at N+1 and rises at N+3.
  - State IDLE after N+4; the next byte can be accepted at N+5.
  - Sustained throughput: one word per 6 cycles.
- busy = state ∈ {SETUP, STROBE, HOLD}, registered alongside state.

Test Plan:
- Reset, then bytes 8'h34 then 8'h12 (in_last=0, back-to-back, LSB_FIRST=1) → data_out=16'h1234 after the 2nd accept edge; l_en low for exactly 2 cycles starting 1 cycle later; word_count=1; in_ready low for 4 cycles.
- LSB_FIRST=0, bytes 8'hAB, 8'hCD → data_out=16'hABCD; single byte 8'h7F with in_last=1 in IDLE → data_out=16'h7F00 and a single strobe.
- in_valid held high continuously with 512 bytes → 256 strobes, word_count wraps to 0; in_ready never high in SETUP/STROBE/HOLD; no byte dropped or duplicated (scoreboard).
- Parameters SETUP_CYC=0, STROBE_CYC=1, HOLD_CYC=0 → l_en low exactly 1 cycle, in the cycle immediately after the 2nd accept edge; next accept possible 2 cycles after the 2nd accept.
- Assert rst_n=0 during the first STROBE cycle → l_en=1, data_out=0, word_count=0 after that edge; in_ready=0 during reset and 1 the cycle after release.
- Byte 8'h55 accepted, then in_valid low for 20 cycles, then 8'hAA → state GOT_LO throughout the gap, l_en stays 1, then data_out=16'hAA55 and a normal strobe.
